// File: rtl/rc_sched_pkg.sv
// Shared definitions for the reconfiguration scheduler: FSM encoding,
// default parameter values and the bitstream segment address helper.
package rc_sched_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ISOLATE = 3'd1;
  localparam logic [2:0] ST_START   = 3'd2;
  localparam logic [2:0] ST_WAIT    = 3'd3;
  localparam logic [2:0] ST_RELEASE = 3'd4;

  localparam int          DEF_NUM_RR     = 3;
  localparam int          DEF_NUM_RM     = 3;
  localparam int          DEF_SEL_W      = 2;
  localparam logic [31:0] DEF_BASE_ADDR  = 32'h0;
  localparam logic [31:0] DEF_SEG_STRIDE = 32'h20;
  localparam int          DEF_SEG_SIZE   = 16;
  localparam int          DEF_HDR_SIZE   = 16;
  localparam int          DEF_TIMEOUT    = 1024;

  // Segments are laid out region-major: all RMs of region 0, then region 1, ...
  function automatic logic [31:0] seg_addr(input logic [31:0] base, input int rr,
                                           input int rm, input int num_rm,
                                           input logic [31:0] stride);
    return base + 32'(rr * num_rm + rm) * stride;
  endfunction

endpackage

// File: rtl/rc_rr_arbiter.sv
// Combinational round-robin pick: first pending region at or after ptr,
// wrapping modulo NUM_RR.
module rc_rr_arbiter
  import rc_sched_pkg::*;
#(
  parameter int NUM_RR = DEF_NUM_RR,
  parameter int PTR_W  = (NUM_RR > 1) ? $clog2(NUM_RR) : 1
) (
  input  logic [NUM_RR-1:0] pending,
  input  logic [PTR_W-1:0]  ptr,
  output logic [PTR_W-1:0]  grant,
  output logic              valid
);

  int idx;

  // Scan from the farthest offset down so the nearest pending region wins.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = 0;
    for (int i = NUM_RR - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % NUM_RR;
      if (pending[idx]) begin
        grant = PTR_W'(idx);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rc_scheduler.sv
// Reconfiguration scheduler: tracks the RM loaded in each region and serves
// mismatched regions one at a time through the icapi port.
module rc_scheduler
  import rc_sched_pkg::*;
#(
  parameter int          NUM_RR     = DEF_NUM_RR,
  parameter int          NUM_RM     = DEF_NUM_RM,
  parameter int          SEL_W      = DEF_SEL_W,
  parameter logic [31:0] BASE_ADDR  = DEF_BASE_ADDR,
  parameter logic [31:0] SEG_STRIDE = DEF_SEG_STRIDE,
  parameter int          SEG_SIZE   = DEF_SEG_SIZE,
  parameter int          HDR_SIZE   = DEF_HDR_SIZE,
  parameter int          TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                    clock,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [NUM_RR*SEL_W-1:0] rm_sel,
  output logic                    rc_start,
  output logic                    rc_bop,
  output logic [31:0]             rc_baddr,
  output logic [31:0]             rc_bsize,
  input  logic                    rc_done,
  output logic [NUM_RR-1:0]       rr_isolate,
  output logic [NUM_RR-1:0]       rr_loaded_valid,
  output logic [NUM_RR*SEL_W-1:0] rr_loaded,
  output logic                    busy,
  output logic                    err_timeout
);

  localparam int PTR_W = (NUM_RR > 1) ? $clog2(NUM_RR) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [2:0]        state;
  logic [2:0]        state_next;
  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  g_rr;
  logic [SEL_W-1:0]  g_rm;
  logic [PTR_W-1:0]  arb_grant;
  logic              arb_valid;
  logic [NUM_RR-1:0] pending;
  logic [CNT_W-1:0]  wait_cnt;

  assign rc_bop = 1'b1;

  always_comb begin
    pending = '0;
    for (int r = 0; r < NUM_RR; r++) begin
      if (int'(rm_sel[r*SEL_W +: SEL_W]) < NUM_RM &&
          (!rr_loaded_valid[r] ||
           rr_loaded[r*SEL_W +: SEL_W] != rm_sel[r*SEL_W +: SEL_W]))
        pending[r] = 1'b1;
    end
  end

  rc_rr_arbiter #(
    .NUM_RR (NUM_RR),
    .PTR_W  (PTR_W)
  ) u_arbiter (
    .pending (pending),
    .ptr     (rr_ptr),
    .grant   (arb_grant),
    .valid   (arb_valid)
  );

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (enable && arb_valid) state_next = ST_ISOLATE;
      ST_ISOLATE: state_next = ST_START;
      ST_START:   state_next = ST_WAIT;
      ST_WAIT:    if (rc_done || wait_cnt == CNT_W'(TIMEOUT - 1)) state_next = ST_RELEASE;
      ST_RELEASE: state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // err_timeout is raised one edge early so it lands on the last WAIT cycle.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state           <= ST_IDLE;
      rr_ptr          <= '0;
      g_rr            <= '0;
      g_rm            <= '0;
      wait_cnt        <= '0;
      rc_start        <= 1'b0;
      rc_baddr        <= '0;
      rc_bsize        <= '0;
      rr_isolate      <= '0;
      rr_loaded_valid <= '0;
      rr_loaded       <= '0;
      busy            <= 1'b0;
      err_timeout     <= 1'b0;
    end else begin
      state       <= state_next;
      busy        <= (state_next != ST_IDLE);
      rc_start    <= 1'b0;
      err_timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (state_next == ST_ISOLATE) begin
            g_rr       <= arb_grant;
            g_rm       <= rm_sel[arb_grant*SEL_W +: SEL_W];
            rr_isolate <= NUM_RR'(1) << arb_grant;
          end
        end
        ST_ISOLATE: begin
          rc_baddr <= seg_addr(BASE_ADDR, int'(g_rr), int'(g_rm), NUM_RM, SEG_STRIDE);
          rc_bsize <= 32'(SEG_SIZE + HDR_SIZE);
          rc_start <= 1'b1;
        end
        ST_START: begin
          rr_loaded_valid[g_rr] <= 1'b0;
          wait_cnt              <= '0;
        end
        ST_WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (rc_done) begin
            rr_loaded[g_rr*SEL_W +: SEL_W] <= g_rm;
            rr_loaded_valid[g_rr]          <= 1'b1;
          end else if (wait_cnt == CNT_W'(TIMEOUT - 2)) begin
            err_timeout <= 1'b1;
          end
        end
        ST_RELEASE: begin
          rr_isolate <= '0;
          rr_ptr     <= (g_rr == PTR_W'(NUM_RR - 1)) ? '0 : g_rr + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rc_scheduler.sv
// Directed testbench for rc_scheduler with hand-computed expected values.
module tb_rc_scheduler;

  logic        clock = 1'b0;
  logic        rst;
  logic        enable;
  logic [5:0]  rm_sel;
  logic        rc_start;
  logic        rc_bop;
  logic [31:0] rc_baddr;
  logic [31:0] rc_bsize;
  logic        rc_done;
  logic [2:0]  rr_isolate;
  logic [2:0]  rr_loaded_valid;
  logic [5:0]  rr_loaded;
  logic        busy;
  logic        err_timeout;

  int vectors = 0;
  int miscompares = 0;

  rc_scheduler dut (
    .clock           (clock),
    .rst             (rst),
    .enable          (enable),
    .rm_sel          (rm_sel),
    .rc_start        (rc_start),
    .rc_bop          (rc_bop),
    .rc_baddr        (rc_baddr),
    .rc_bsize        (rc_bsize),
    .rc_done         (rc_done),
    .rr_isolate      (rr_isolate),
    .rr_loaded_valid (rr_loaded_valid),
    .rr_loaded       (rr_loaded),
    .busy            (busy),
    .err_timeout     (err_timeout)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic en, input logic [5:0] sel, input logic done);
    enable  = en;
    rm_sel  = sel;
    rc_done = done;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One full operation starting in IDLE with the region pending; icapi answers
  // after one WAIT cycle.
  task automatic doOp(input int rr, input int rm, input logic [31:0] addr);
    logic [2:0] onehot;
    onehot = 3'(1 << rr);
    tick();
    checkOutput("grant_isolate", 32'(rr_isolate), 32'(onehot));
    checkOutput("grant_busy", 32'(busy), 32'd1);
    checkOutput("grant_no_start", 32'(rc_start), 32'd0);
    tick();
    checkOutput("start_pulse", 32'(rc_start), 32'd1);
    checkOutput("start_baddr", rc_baddr, addr);
    checkOutput("start_bsize", rc_bsize, 32'd32);
    tick();
    checkOutput("wait_start_low", 32'(rc_start), 32'd0);
    checkOutput("wait_valid_cleared", 32'(rr_loaded_valid[rr]), 32'd0);
    checkOutput("wait_baddr_stable", rc_baddr, addr);
    rc_done = 1'b1;
    tick();
    rc_done = 1'b0;
    checkOutput("done_valid", 32'(rr_loaded_valid[rr]), 32'd1);
    checkOutput("done_loaded", 32'((rr_loaded >> (2 * rr)) & 6'h3), 32'(rm));
    checkOutput("release_isolate", 32'(rr_isolate), 32'(onehot));
    tick();
    checkOutput("idle_isolate", 32'(rr_isolate), 32'd0);
    checkOutput("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 6'b11_11_11, 1'b0);
    tick();
    tick();
    checkOutput("rst_start", 32'(rc_start), 32'd0);
    checkOutput("rst_bop", 32'(rc_bop), 32'd1);
    checkOutput("rst_baddr", rc_baddr, 32'd0);
    checkOutput("rst_bsize", rc_bsize, 32'd0);
    checkOutput("rst_isolate", 32'(rr_isolate), 32'd0);
    checkOutput("rst_valid", 32'(rr_loaded_valid), 32'd0);
    checkOutput("rst_loaded", 32'(rr_loaded), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_err", 32'(err_timeout), 32'd0);
    rst = 1'b0;

    // Initial fill: RR2=2, RR1=1, RR0=0 served in order 0, 1, 2
    applyStimulus(1'b1, 6'b10_01_00, 1'b0);
    doOp(0, 0, 32'h00);
    doOp(1, 1, 32'h80);
    doOp(2, 2, 32'h100);
    checkOutput("fill_valid", 32'(rr_loaded_valid), 32'h7);
    checkOutput("fill_loaded", 32'(rr_loaded), 32'h24);
    tick();
    checkOutput("steady_busy", 32'(busy), 32'd0);

    // Single-region change: RR1 -> RM2
    applyStimulus(1'b1, 6'b10_10_00, 1'b0);
    doOp(1, 2, 32'hA0);
    checkOutput("rr1_loaded", 32'(rr_loaded), 32'h28);
    checkOutput("rr1_valid", 32'(rr_loaded_valid), 32'h7);

    // Timeout on RR2 -> RM1, then retry on its next turn
    applyStimulus(1'b1, 6'b01_10_00, 1'b0);
    tick();
    checkOutput("to_isolate", 32'(rr_isolate), 32'h4);
    tick();
    checkOutput("to_baddr", rc_baddr, 32'hE0);
    tick();
    for (int i = 0; i < 1022; i++) tick();
    checkOutput("to_err_early", 32'(err_timeout), 32'd0);
    tick();
    checkOutput("to_err_pulse", 32'(err_timeout), 32'd1);
    checkOutput("to_valid_low", 32'(rr_loaded_valid), 32'h3);
    tick();
    checkOutput("to_err_single", 32'(err_timeout), 32'd0);
    checkOutput("to_release_isolate", 32'(rr_isolate), 32'h4);
    tick();
    checkOutput("to_idle_isolate", 32'(rr_isolate), 32'd0);
    doOp(2, 1, 32'hE0);
    checkOutput("retry_loaded", 32'(rr_loaded), 32'h18);

    // rm_sel changes during WAIT: latched RM loads first, then the new one
    applyStimulus(1'b1, 6'b01_10_01, 1'b0);
    tick();
    checkOutput("chg_isolate", 32'(rr_isolate), 32'h1);
    tick();
    checkOutput("chg_baddr", rc_baddr, 32'h20);
    tick();
    applyStimulus(1'b1, 6'b01_10_10, 1'b1);
    tick();
    rc_done = 1'b0;
    checkOutput("chg_latched_rm", 32'(rr_loaded), 32'h19);
    checkOutput("chg_valid", 32'(rr_loaded_valid), 32'h7);
    tick();
    doOp(0, 2, 32'h40);
    checkOutput("chg_new_rm", 32'(rr_loaded), 32'h1A);

    // RR1 requests RM3 (no request); a stray rc_done in IDLE is ignored
    applyStimulus(1'b1, 6'b01_11_10, 1'b1);
    tick();
    rc_done = 1'b0;
    checkOutput("stray_done_loaded", 32'(rr_loaded), 32'h1A);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("nosel_busy", 32'(busy), 32'd0);
    end

    // enable low with RR2 pending: nothing starts until enable returns
    applyStimulus(1'b0, 6'b00_11_10, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("disabled_start", 32'(rc_start), 32'd0);
      checkOutput("disabled_isolate", 32'(rr_isolate), 32'd0);
    end
    enable = 1'b1;
    doOp(2, 0, 32'hC0);

    // Reset during WAIT, then a late rc_done must not load anything
    applyStimulus(1'b1, 6'b00_11_00, 1'b0);
    tick();
    tick();
    checkOutput("rstw_baddr", rc_baddr, 32'h00);
    tick();
    tick();
    checkOutput("rstw_in_wait", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rstw_isolate", 32'(rr_isolate), 32'd0);
    checkOutput("rstw_valid", 32'(rr_loaded_valid), 32'd0);
    checkOutput("rstw_loaded", 32'(rr_loaded), 32'd0);
    checkOutput("rstw_busy", 32'(busy), 32'd0);
    checkOutput("rstw_bsize", 32'(rc_bsize), 32'd0);
    tick();
    applyStimulus(1'b0, 6'b11_11_11, 1'b0);
    rst = 1'b0;
    rc_done = 1'b1;
    tick();
    rc_done = 1'b0;
    checkOutput("late_done_valid", 32'(rr_loaded_valid), 32'd0);
    checkOutput("late_done_loaded", 32'(rr_loaded), 32'd0);
    tick();
    checkOutput("late_done_start", 32'(rc_start), 32'd0);
    checkOutput("late_done_busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
